next_line_prefetcher: RTL and testbench

NEXT_LINE_PREFETCHER -- requirements
Module: next_line_prefetcher

---
 rtl/pf_pkg.sv | 30 +++
 rtl/next_line_prefetcher.sv | 119 +++++++++++
 tb/tb_next_line_prefetcher.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pf_pkg.sv
// Shared types and constants for the next-line prefetcher.
package pf_pkg;

  localparam int LINE_BITS     = 256;
  localparam int OFFSET_BITS   = 5;
  localparam int PAGE_BITS     = 12;
  localparam int ADDR_BITS     = 32;
  localparam int LINE_NUM_BITS = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FETCH = 2'd2,
    READY = 2'd3
  } pf_state_e;

  // Line-aligned address of the line following the one containing addr.
  // The 27-bit line number never wraps because last-in-page misses are dropped.
  function automatic logic [ADDR_BITS-1:0] next_line_addr(input logic [ADDR_BITS-1:0] addr);
    logic [LINE_NUM_BITS-1:0] line_num;
    line_num       = addr[ADDR_BITS-1:OFFSET_BITS] + LINE_NUM_BITS'(1);
    next_line_addr = {line_num, {OFFSET_BITS{1'b0}}};
  endfunction

  // True when addr falls in the last line of its 4 KiB page.
  function automatic logic is_last_line_in_page(input logic [ADDR_BITS-1:0] addr);
    is_last_line_in_page = &addr[PAGE_BITS-1:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: on a demand miss, fetches the following cache line
// into a one-entry buffer once the cache stops using physical memory, then
// offers it to the cache until the cache acknowledges the fill.
module next_line_prefetcher
  import pf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prefetch_start,
  input  logic [ADDR_BITS-1:0]  miss_addr,
  input  logic                  demand_busy,
  input  logic                  pf_ack,
  input  logic                  pf_lru,
  output logic                  pf_pmem_read,
  output logic [ADDR_BITS-1:0]  pf_pmem_address,
  input  logic                  pf_pmem_resp,
  input  logic [LINE_BITS-1:0]  pf_pmem_rdata,
  output logic                  prefetch_ready,
  output logic [LINE_BITS-1:0]  pf_line,
  output logic [ADDR_BITS-1:0]  pf_addr,
  output logic                  pf_cache_way
);

  pf_state_e             state_q, state_d;
  logic                  start_q, start_d;
  logic [ADDR_BITS-1:0]  pf_addr_q, pf_addr_d;
  logic [LINE_BITS-1:0]  pf_line_q, pf_line_d;
  logic                  pf_way_q, pf_way_d;
  logic [ADDR_BITS-1:0]  last_pf_q, last_pf_d;
  logic                  last_valid_q, last_valid_d;

  logic                  start_evt;
  logic [ADDR_BITS-1:0]  target;
  logic                  accept;

  // Start qualification: rising edge of the held start, not at a page end,
  // and not a repeat of the line most recently fetched.
  always_comb begin
    start_evt = prefetch_start & ~start_q;
    target    = next_line_addr(miss_addr);
    accept    = start_evt
              & ~is_last_line_in_page(miss_addr)
              & ~(last_valid_q & (target == last_pf_q));
  end

  // Next-state and datapath updates for the IDLE/PEND/FETCH/READY flow.
  always_comb begin
    state_d      = state_q;
    start_d      = prefetch_start;
    pf_addr_d    = pf_addr_q;
    pf_line_d    = pf_line_q;
    pf_way_d     = pf_way_q;
    last_pf_d    = last_pf_q;
    last_valid_d = last_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pf_addr_d = target;
          state_d   = PEND;
        end
      end
      PEND: begin
        // A newer miss replaces the pending target and restarts the wait.
        if (accept) begin
          pf_addr_d = target;
        end else if (!demand_busy) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (pf_pmem_resp) begin
          pf_line_d    = pf_pmem_rdata;
          pf_way_d     = pf_lru;
          last_pf_d    = pf_addr_q;
          last_valid_d = 1'b1;
          state_d      = READY;
        end
      end
      READY: begin
        if (pf_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset forces IDLE and clears the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      pf_addr_q    <= '0;
      pf_line_q    <= '0;
      pf_way_q     <= 1'b0;
      last_pf_q    <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      pf_addr_q    <= pf_addr_d;
      pf_line_q    <= pf_line_d;
      pf_way_q     <= pf_way_d;
      last_pf_q    <= last_pf_d;
      last_valid_q <= last_valid_d;
    end
  end

  // Outputs decode straight from state so reset drops the read request at once.
  always_comb begin
    pf_pmem_read    = (state_q == FETCH);
    pf_pmem_address = pf_addr_q;
    prefetch_ready  = (state_q == READY);
    pf_line         = pf_line_q;
    pf_addr         = pf_addr_q;
    pf_cache_way    = pf_way_q;
  end

endmodule

// File: tb/tb_next_line_prefetcher.sv
// Directed testbench for next_line_prefetcher.
module tb_next_line_prefetcher;
  import pf_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 prefetch_start;
  logic [ADDR_BITS-1:0] miss_addr;
  logic                 demand_busy;
  logic                 pf_ack;
  logic                 pf_lru;
  logic                 pf_pmem_read;
  logic [ADDR_BITS-1:0] pf_pmem_address;
  logic                 pf_pmem_resp;
  logic [LINE_BITS-1:0] pf_pmem_rdata;
  logic                 prefetch_ready;
  logic [LINE_BITS-1:0] pf_line;
  logic [ADDR_BITS-1:0] pf_addr;
  logic                 pf_cache_way;

  int checkCount = 0;
  int failCount  = 0;
  int burstCount = 0;
  logic [ADDR_BITS-1:0] lastBurstAddr = '0;
  logic prevRead = 1'b0;

  next_line_prefetcher dut (
    .clk             (clk),
    .rst             (rst),
    .prefetch_start  (prefetch_start),
    .miss_addr       (miss_addr),
    .demand_busy     (demand_busy),
    .pf_ack          (pf_ack),
    .pf_lru          (pf_lru),
    .pf_pmem_read    (pf_pmem_read),
    .pf_pmem_address (pf_pmem_address),
    .pf_pmem_resp    (pf_pmem_resp),
    .pf_pmem_rdata   (pf_pmem_rdata),
    .prefetch_ready  (prefetch_ready),
    .pf_line         (pf_line),
    .pf_addr         (pf_addr),
    .pf_cache_way    (pf_cache_way)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count read bursts and remember where each one started.
  always @(posedge clk) begin
    if (pf_pmem_read && !prevRead) begin
      burstCount    = burstCount + 1;
      lastBurstAddr = pf_pmem_address;
    end
    prevRead = pf_pmem_read;
  end

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [LINE_BITS-1:0] actual,
                             input logic [LINE_BITS-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the demand-side inputs, then advance to just after the next edge.
  task automatic applyStimulus(input logic start, input logic [ADDR_BITS-1:0] addr,
                               input logic busy);
    prefetch_start = start;
    miss_addr      = addr;
    demand_busy    = busy;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the read, answer it after respDelay cycles with data/lru,
  // check the buffered line, hold it across lru toggles, then acknowledge.
  task automatic serviceFetch(input string tag, input logic [ADDR_BITS-1:0] expAddr,
                              input int respDelay, input logic [LINE_BITS-1:0] data,
                              input logic lru);
    int waited = 0;
    while (!pf_pmem_read && waited < 30) begin
      applyStimulus(prefetch_start, miss_addr, demand_busy);
      waited++;
    end
    checkOutput({tag, "_readSeen"}, LINE_BITS'(pf_pmem_read), 1);
    checkOutput({tag, "_readAddr"}, LINE_BITS'(pf_pmem_address), LINE_BITS'(expAddr));
    for (int i = 0; i < respDelay - 1; i++) begin
      applyStimulus(prefetch_start, miss_addr, demand_busy);
    end
    checkOutput({tag, "_readHeld"}, LINE_BITS'(pf_pmem_read), 1);
    checkOutput({tag, "_notReadyYet"}, LINE_BITS'(prefetch_ready), 0);
    pf_pmem_resp  = 1'b1;
    pf_pmem_rdata = data;
    pf_lru        = lru;
    applyStimulus(prefetch_start, miss_addr, demand_busy);
    pf_pmem_resp  = 1'b0;
    pf_pmem_rdata = '0;
    checkOutput({tag, "_ready"}, LINE_BITS'(prefetch_ready), 1);
    checkOutput({tag, "_readDropped"}, LINE_BITS'(pf_pmem_read), 0);
    checkOutput({tag, "_line"}, pf_line, data);
    checkOutput({tag, "_way"}, LINE_BITS'(pf_cache_way), LINE_BITS'(lru));
    for (int i = 0; i < 2; i++) begin
      pf_lru = ~pf_lru;
      applyStimulus(prefetch_start, miss_addr, demand_busy);
      checkOutput({tag, "_wayHeld"}, LINE_BITS'(pf_cache_way), LINE_BITS'(lru));
      checkOutput({tag, "_addrHeld"}, LINE_BITS'(pf_addr), LINE_BITS'(expAddr));
    end
    pf_ack = 1'b1;
    #1;
    checkOutput({tag, "_readyOnAck"}, LINE_BITS'(prefetch_ready), 1);
    applyStimulus(prefetch_start, miss_addr, demand_busy);
    pf_ack = 1'b0;
    checkOutput({tag, "_idleAfterAck"}, LINE_BITS'(prefetch_ready), 0);
  endtask

  initial begin
    int bursts0;
    logic sawRead;
    logic sawReady;

    rst            = 1'b0;
    prefetch_start = 1'b0;
    miss_addr      = '0;
    demand_busy    = 1'b0;
    pf_ack         = 1'b0;
    pf_lru         = 1'b0;
    pf_pmem_resp   = 1'b0;
    pf_pmem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", LINE_BITS'(prefetch_ready), 0);
    checkOutput("rstRead", LINE_BITS'(pf_pmem_read), 0);
    checkOutput("rstLine", pf_line, 0);
    checkOutput("rstAddr", LINE_BITS'(pf_addr), 0);
    checkOutput("rstPmemAddr", LINE_BITS'(pf_pmem_address), 0);
    checkOutput("rstWay", LINE_BITS'(pf_cache_way), 0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);

    // Single prefetch with demand busy for 4 cycles and 5-cycle pmem latency.
    applyStimulus(1'b1, 32'h0000_1040, 1'b1);
    checkOutput("single_pendAddr", LINE_BITS'(pf_addr), LINE_BITS'(32'h0000_1060));
    checkOutput("single_noReadBusy", LINE_BITS'(pf_pmem_read), 0);
    applyStimulus(1'b1, 32'h0000_1040, 1'b1);
    applyStimulus(1'b0, 32'h0000_1040, 1'b1);
    applyStimulus(1'b0, 32'h0000_1040, 1'b1);
    checkOutput("single_stillPend", LINE_BITS'(pf_pmem_read), 0);
    demand_busy = 1'b0;
    serviceFetch("single", 32'h0000_1060, 5, {8{32'hA5A5_0000 + 32'h0000_1111}}, 1'b0);

    // Last line of a page: nothing should be fetched.
    sawRead  = 1'b0;
    sawReady = 1'b0;
    applyStimulus(1'b1, 32'h0000_2FE0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sawRead  = sawRead | pf_pmem_read;
      sawReady = sawReady | prefetch_ready;
      applyStimulus(i < 5, 32'h0000_2FE0, 1'b0);
    end
    checkOutput("page_noRead", LINE_BITS'(sawRead), 0);
    checkOutput("page_noReady", LINE_BITS'(sawReady), 0);

    // Duplicate filter: the second miss at 0x100 must not refetch 0x120.
    bursts0 = burstCount;
    applyStimulus(1'b1, 32'h0000_0100, 1'b0);
    serviceFetch("dup", 32'h0000_0120, 2, {4{64'h0123_4567_89AB_CDEF}}, 1'b0);
    applyStimulus(1'b0, 32'h0000_0100, 1'b0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0000_0100, 1'b0);
    checkOutput("dup_burstCount", LINE_BITS'(burstCount - bursts0), 1);
    checkOutput("dup_burstAddr", LINE_BITS'(lastBurstAddr), LINE_BITS'(32'h0000_0120));
    checkOutput("dup_noReady", LINE_BITS'(prefetch_ready), 0);

    // Newest miss wins in PEND; also captures lru=1 and holds it in READY.
    bursts0 = burstCount;
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    applyStimulus(1'b0, 32'h0000_0200, 1'b1);
    applyStimulus(1'b1, 32'h0000_0400, 1'b1);
    checkOutput("ovr_pendAddr", LINE_BITS'(pf_addr), LINE_BITS'(32'h0000_0420));
    applyStimulus(1'b1, 32'h0000_0400, 1'b1);
    demand_busy = 1'b0;
    serviceFetch("ovr", 32'h0000_0420, 3, {16{16'hBEEF}}, 1'b1);
    checkOutput("ovr_burstCount", LINE_BITS'(burstCount - bursts0), 1);
    checkOutput("ovr_burstAddr", LINE_BITS'(lastBurstAddr), LINE_BITS'(32'h0000_0420));
    applyStimulus(1'b0, 32'h0000_0400, 1'b0);

    // Reset in the middle of FETCH, then a stale response.
    applyStimulus(1'b1, 32'h0000_0800, 1'b0);
    applyStimulus(1'b1, 32'h0000_0800, 1'b0);
    checkOutput("rstMid_reading", LINE_BITS'(pf_pmem_read), 1);
    rst = 1'b0;
    #1;
    checkOutput("rstMid_asyncDrop", LINE_BITS'(pf_pmem_read), 0);
    applyStimulus(1'b0, 32'h0000_0800, 1'b0);
    rst          = 1'b1;
    pf_pmem_resp = 1'b1;
    pf_pmem_rdata = {8{32'hDEAD_BEEF}};
    applyStimulus(1'b0, 32'h0000_0800, 1'b0);
    pf_pmem_resp  = 1'b0;
    pf_pmem_rdata = '0;
    checkOutput("rstMid_lateResp", LINE_BITS'(prefetch_ready), 0);
    checkOutput("rstMid_lineClear", pf_line, 0);
    applyStimulus(1'b0, 32'h0000_0800, 1'b0);
    checkOutput("rstMid_stayIdle", LINE_BITS'(pf_pmem_read), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
